// File: rtl/conv_pkg.sv
// Shared definitions for the conv accelerator's output side: FSM states and frame sizing.
package conv_pkg;

  typedef enum logic {COLLECT, STREAM} output_state_t;

  // Valid-convolution output count; a kernel size of 0 behaves as 1.
  function automatic int unsigned out_count(input int unsigned k, input int unsigned r,
                                            input int unsigned c);
    int unsigned kf;
    kf = (k == 0) ? 1 : k;
    return (r - kf + 1) * (c - kf + 1);
  endfunction

endpackage

// File: rtl/output_mems_if.sv
// AXI-Stream output bundle (data, valid, ready, last).
interface output_mems_if #(
  parameter int unsigned OUTW = 24
);
  logic [OUTW-1:0] tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/counter.sv
// Up-counter with enable, synchronous clear and active-low asynchronous clear.
module counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);
  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/memory.sv
// Simple dual-port RAM: one write port, one read port with a registered 1-cycle read.
module memory #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned SIZE  = 72
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [$clog2(SIZE)-1:0] waddr_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    re_i,
  input  logic [$clog2(SIZE)-1:0] raddr_i,
  output logic [WIDTH-1:0]        rdata_o
);
  logic [WIDTH-1:0] mem_q [SIZE];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/out_skid.sv
// Two-entry valid/ready register buffer; free_o counts slots available after this cycle's pop.
module out_skid #(
  parameter int unsigned Width = 25
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       free_o
);
  logic [1:0]       count_q, count_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic             pop;

  always_comb begin
    pop     = (count_q != 2'd0) && out_ready_i;
    count_d = count_q + {1'b0, in_valid_i} - {1'b0, pop};
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop) begin
      if (count_q == 2'd2) begin
        head_d = tail_q;
        if (in_valid_i) begin
          tail_d = in_data_i;
        end
      end else if (in_valid_i) begin
        head_d = in_data_i;
      end
    end else if (in_valid_i) begin
      if (count_q == 2'd0) begin
        head_d = in_data_i;
      end else begin
        tail_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    out_valid_o = (count_q != 2'd0);
    out_data_o  = head_q;
    free_o      = 2'd2 - count_q + {1'b0, pop};
  end
endmodule

// File: rtl/output_mems.sv
// Captures a frame of conv results into Y memory, then streams it out over AXI-Stream.
module output_mems
  import conv_pkg::*;
#(
  parameter  int unsigned OUTW   = 24,
  parameter  int unsigned R      = 9,
  parameter  int unsigned C      = 8,
  parameter  int unsigned MAXK   = 4,
  localparam int unsigned K_BITS = $clog2(MAXK + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [K_BITS-1:0]     K,
  input  logic [OUTW-1:0]       res_data,
  input  logic                  res_valid,
  output logic                  res_ready,
  output logic                  compute_finished,
  output_mems_if.master         axis
);
  localparam int unsigned Y_SIZE      = R * C;
  localparam int unsigned Y_ADDR_BITS = $clog2(R * C);
  localparam int unsigned CntW        = $clog2(R * C + 1);

  output_state_t   state_q, state_d;
  logic [CntW-1:0] wr_cnt, rd_cnt;
  logic [CntW-1:0] out_cnt_q, out_cnt_d, frame_cnt;
  logic            cf_q, cf_d;
  logic            rd_pending_q, rd_pending_d;
  logic            rd_last_q, rd_last_d;
  logic            wr_en, last_write, rd_issue, exit_stream;
  logic            skid_valid;
  logic [OUTW:0]   skid_data;
  logic [1:0]      skid_free;
  logic [OUTW-1:0] y_rdata;

  always_comb begin
    // The frame size is taken from K on the first write and held thereafter.
    frame_cnt    = (wr_cnt == '0) ? CntW'(out_count(32'(K), R, C)) : out_cnt_q;
    wr_en        = (state_q == COLLECT) && res_valid;
    last_write   = wr_en && (wr_cnt == frame_cnt - CntW'(1));
    out_cnt_d    = (wr_en && (wr_cnt == '0)) ? frame_cnt : out_cnt_q;
    cf_d         = last_write;
    // Issue only if the skid can absorb this read on top of the one already in flight.
    rd_issue     = (state_q == STREAM) && (rd_cnt < out_cnt_q) &&
                   ({1'b0, rd_pending_q} < skid_free);
    rd_pending_d = rd_issue;
    rd_last_d    = rd_issue && (rd_cnt == out_cnt_q - CntW'(1));
    exit_stream  = (state_q == STREAM) && skid_valid && axis.tready && skid_data[OUTW];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (last_write)  state_d = STREAM;
      STREAM:  if (exit_stream) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= COLLECT;
      out_cnt_q    <= '0;
      cf_q         <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_cnt_q    <= out_cnt_d;
      cf_q         <= cf_d;
      rd_pending_q <= rd_pending_d;
      rd_last_q    <= rd_last_d;
    end
  end

  always_comb begin
    res_ready        = (state_q == COLLECT);
    compute_finished = cf_q;
    axis.tvalid      = skid_valid;
    axis.tdata       = skid_data[OUTW-1:0];
    axis.tlast       = skid_data[OUTW];
  end

  counter #(.Width(CntW)) u_wr_cnt (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (exit_stream),
    .en_i   (wr_en),
    .cnt_o  (wr_cnt)
  );

  counter #(.Width(CntW)) u_rd_cnt (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (exit_stream),
    .en_i   (rd_issue),
    .cnt_o  (rd_cnt)
  );

  memory #(.WIDTH(OUTW), .SIZE(Y_SIZE)) u_y_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_cnt[Y_ADDR_BITS-1:0]),
    .wdata_i (res_data),
    .re_i    (rd_issue),
    .raddr_i (rd_cnt[Y_ADDR_BITS-1:0]),
    .rdata_o (y_rdata)
  );

  out_skid #(.Width(OUTW + 1)) u_skid (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .in_valid_i  (rd_pending_q),
    .in_data_i   ({rd_last_q, y_rdata}),
    .out_valid_o (skid_valid),
    .out_data_o  (skid_data),
    .out_ready_i (axis.tready),
    .free_o      (skid_free)
  );
endmodule

// File: tb/tb_output_mems.sv
// Directed/random bench for output_mems: frame capture, streaming order, TLAST, backpressure, reset.
module tb_output_mems;
  localparam int R = 9;
  localparam int C = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  K = 3'd0;
  logic [23:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        compute_finished;

  output_mems_if #(.OUTW(24)) axis_if ();

  output_mems #(.OUTW(24), .R(R), .C(C), .MAXK(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .K                (K),
    .res_data         (res_data),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .compute_finished (compute_finished),
    .axis             (axis_if)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [23:0] vals[$];
  logic [23:0] exp_q[$];

  function automatic int frame_len(input int k);
    int kk;
    kk = (k == 0) ? 1 : k;
    return (R - kk + 1) * (C - kk + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      vals.push_back(rnd ? 24'($urandom) : 24'(i + 1));
    end
  endtask

  task automatic reset_checks();
    chk("rst_tvalid", 64'(axis_if.tvalid), 64'd0);
    chk("rst_tlast", 64'(axis_if.tlast), 64'd0);
    chk("rst_tdata", 64'(axis_if.tdata), 64'd0);
    chk("rst_ready", 64'(res_ready), 64'd1);
    chk("rst_cf", 64'(compute_finished), 64'd0);
  endtask

  // Writes vals as one frame of kernel size k, then checks the completion pulse and latency.
  task automatic write_frame(input int k, input bit hold, input logic [23:0] hold_val);
    int n;
    n = frame_len(k);
    for (int i = 0; i < n; i++) begin
      K = 3'(k);
      res_data = vals[i];
      res_valid = 1'b1;
      chk("wr_ready", 64'(res_ready), 64'd1);
      chk("wr_cf_low", 64'(compute_finished), 64'd0);
      chk("wr_tvalid", 64'(axis_if.tvalid), 64'd0);
      step();
    end
    res_valid = hold;
    res_data = hold ? hold_val : 24'd0;
    exp_q = vals;
    chk("cf_pulse", 64'(compute_finished), 64'd1);
    chk("cf_ready_low", 64'(res_ready), 64'd0);
    chk("cf_tvalid", 64'(axis_if.tvalid), 64'd0);
    step();
    chk("cf_drop", 64'(compute_finished), 64'd0);
    chk("lat_tvalid_n1", 64'(axis_if.tvalid), 64'd0);
    step();
    chk("lat_tvalid_n2", 64'(axis_if.tvalid), 64'd1);
  endtask

  // mode 0: TREADY=1, 1: 1,0,0,1 pattern, 2: random. abort_at >= 0 resets on that beat index.
  task automatic drain(input int mode, input int abort_at);
    int n;
    int idx;
    int cyc;
    bit tr;
    n = exp_q.size();
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 4000) begin
      case (mode)
        0:       tr = 1'b1;
        1:       tr = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: tr = 1'($urandom % 2);
      endcase
      axis_if.tready = tr;
      if (abort_at == idx) begin
        reset_n = 1'b0;
        res_valid = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        return;
      end
      chk("strm_ready", 64'(res_ready), 64'd0);
      if (mode == 0) chk("no_bubble", 64'(axis_if.tvalid), 64'd1);
      if (axis_if.tvalid) begin
        chk("tdata", 64'(axis_if.tdata), 64'(exp_q[idx]));
        chk("tlast", 64'(axis_if.tlast), 64'(idx == n - 1));
        if (tr) idx++;
      end
      step();
      cyc++;
    end
    chk("beats", 64'(idx), 64'(n));
    if (mode == 0) chk("throughput_cycles", 64'(cyc), 64'(n));
    chk("ready_back", 64'(res_ready), 64'd1);
    chk("tvalid_idle", 64'(axis_if.tvalid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] h;
    axis_if.tready = 1'b0;
    step();
    step();
    reset_checks();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    reset_checks();

    // K=3, values 1..42, TREADY high.
    vals.delete(); fill(frame_len(3), 1'b0);
    write_frame(3, 1'b0, 24'd0);
    drain(0, -1);

    // Same frame under 1,0,0,1 backpressure.
    vals.delete(); fill(frame_len(3), 1'b0);
    write_frame(3, 1'b0, 24'd0);
    drain(1, -1);

    // K=1 random, random backpressure.
    vals.delete(); fill(frame_len(1), 1'b1);
    write_frame(1, 1'b0, 24'd0);
    drain(2, -1);

    // K=4 with negative extremes at the front.
    vals.delete();
    vals.push_back(24'hFFFFFF);
    vals.push_back(24'h800000);
    fill(frame_len(4) - 2, 1'b1);
    write_frame(4, 1'b0, 24'd0);
    drain(0, -1);

    // Reset while beat 20 is on the bus, then a clean frame.
    vals.delete(); fill(frame_len(3), 1'b1);
    write_frame(3, 1'b0, 24'd0);
    drain(0, 19);
    reset_checks();
    vals.delete(); fill(frame_len(3), 1'b1);
    write_frame(3, 1'b0, 24'd0);
    drain(0, -1);

    // Back-to-back frames with res_valid held through STREAM.
    h = 24'($urandom);
    vals.delete(); fill(frame_len(3), 1'b1);
    write_frame(3, 1'b1, h);
    vals.delete(); vals.push_back(h); fill(frame_len(2) - 1, 1'b1);
    drain(2, -1);
    write_frame(2, 1'b0, 24'd0);
    drain(0, -1);

    // K=0 behaves as K=1.
    vals.delete(); fill(frame_len(0), 1'b1);
    write_frame(0, 1'b0, 24'd0);
    drain(0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
